pkt_deframer: RTL and testbench

PKT_DEFRAMER -- requirements
Module: pkt_deframer

---
 rtl/pkt_deframer.sv | 146 ++++++++++++++
 tb/tb_pkt_deframer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_deframer.sv
// Frame deframer: stores the fixed-length header in a flat register and packs
// the payload bytes into OUT_BYTES-wide words with a one-cycle write strobe.
module pkt_deframer #(
    parameter int HDR_WORDS     = 31,
    parameter int PAYLOAD_BYTES = 400,
    parameter int OUT_BYTES     = 2,
    parameter int BIG_ENDIAN    = 1,
    localparam int WORDS        = PAYLOAD_BYTES / OUT_BYTES,
    localparam int AW           = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                    clock,
    input  logic                    aclr,
    input  logic                    sclr,
    input  logic                    ena,
    input  logic                    din_valid,
    input  logic [7:0]              datain,
    output logic                    wren,
    output logic [8*OUT_BYTES-1:0]  data,
    output logic [AW-1:0]           waddr,
    output logic [32*HDR_WORDS-1:0] o_header,
    output logic                    header_ena,
    output logic                    pkt_done,
    output logic                    err_short
);

    localparam int HDR_BYTES   = 4 * HDR_WORDS;
    localparam int TOTAL_BYTES = HDR_BYTES + PAYLOAD_BYTES;
    localparam int CW          = $clog2(TOTAL_BYTES + 1);
    localparam int PW          = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY,
        DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [PW-1:0]          wpos;
    logic [AW-1:0]          word_idx;
    logic                   blocked;
    logic [8*OUT_BYTES-1:0] acc;
    logic [8*OUT_BYTES-1:0] next_word;
    logic                   last_lane;

    assign last_lane = (wpos == PW'(OUT_BYTES - 1));

    // Merge the incoming byte into its lane of the partially built word.
    always_comb begin
        // NOTE: default assignment first keeps this block free of latches.
        next_word = acc;
        for (int p = 0; p < OUT_BYTES; p++) begin
            if (wpos == PW'(p)) begin
                if (BIG_ENDIAN != 0) next_word[8*(OUT_BYTES-1-p) +: 8] = datain;
                else                 next_word[8*p +: 8]               = datain;
            end
        end
    end

    // NOTE: acc carries no reset; every lane is rewritten before a word is emitted.
    always_ff @(posedge clock) begin
        if (state == PAY && ena && din_valid) acc <= next_word;
    end

    // blocked keeps a frame interrupted by reset from being picked up mid-stream.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state      <= IDLE;
            cnt        <= '0;
            wpos       <= '0;
            word_idx   <= '0;
            blocked    <= 1'b1;
            wren       <= 1'b0;
            data       <= '0;
            waddr      <= '0;
            o_header   <= '0;
            header_ena <= 1'b0;
            pkt_done   <= 1'b0;
            err_short  <= 1'b0;
        end else if (sclr) begin
            state      <= IDLE;
            cnt        <= '0;
            wpos       <= '0;
            word_idx   <= '0;
            blocked    <= 1'b1;
            wren       <= 1'b0;
            data       <= '0;
            waddr      <= '0;
            o_header   <= '0;
            header_ena <= 1'b0;
            pkt_done   <= 1'b0;
            err_short  <= 1'b0;
        end else begin
            // NOTE: non-blocking only, so every branch below sees pre-edge state.
            wren      <= 1'b0;
            pkt_done  <= 1'b0;
            err_short <= 1'b0;
            if (!ena) begin
                err_short  <= (state == HDR) || (state == PAY);
                state      <= IDLE;
                cnt        <= '0;
                wpos       <= '0;
                word_idx   <= '0;
                waddr      <= '0;
                header_ena <= 1'b0;
                blocked    <= 1'b0;
            end else if (din_valid) begin
                unique case (state)
                    IDLE, HDR: begin
                        if (state == HDR || !blocked) begin
                            for (int k = 0; k < HDR_BYTES; k++) begin
                                if (cnt == CW'(k)) o_header[8*(HDR_BYTES-1-k) +: 8] <= datain;
                            end
                            cnt <= cnt + 1'b1;
                            if (cnt == CW'(HDR_BYTES - 1)) begin
                                state      <= PAY;
                                header_ena <= 1'b1;
                            end else begin
                                state <= HDR;
                            end
                        end
                    end
                    PAY: begin
                        cnt <= cnt + 1'b1;
                        if (last_lane) begin
                            wren     <= 1'b1;
                            data     <= next_word;
                            waddr    <= word_idx;
                            word_idx <= word_idx + 1'b1;
                            wpos     <= '0;
                        end else begin
                            wpos <= wpos + 1'b1;
                        end
                        if (cnt == CW'(TOTAL_BYTES - 1)) begin
                            state    <= DONE;
                            pkt_done <= 1'b1;
                        end
                    end
                    default: ; // DONE swallows trailing bytes until ena drops
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pkt_deframer.sv
// Bench for pkt_deframer: default big-endian instance driven by frame
// sequences, plus a little-endian 32-bit instance driven from a vector table.
module tb_pkt_deframer;

    localparam int HW    = 31;
    localparam int HB    = 4 * HW;
    localparam int PB    = 400;
    localparam int OB    = 2;
    localparam int NW    = PB / OB;
    localparam int FRAME = HB + PB;

    logic            clock = 1'b0;
    logic            aclr, sclr;
    logic            ena, din_valid;
    logic [7:0]      datain;
    logic            wren;
    logic [15:0]     data;
    logic [7:0]      waddr;
    logic [32*HW-1:0] o_header;
    logic            header_ena, pkt_done, err_short;

    logic            ena2, din_valid2;
    logic [7:0]      datain2;
    logic            wren2;
    logic [31:0]     data2;
    logic [0:0]      waddr2;
    logic [31:0]     o_header2;
    logic            header_ena2, pkt_done2, err_short2;

    typedef struct {
        logic [31:0] data;
        int          waddr;
        logic        done;
    } exp_t;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] pay;
        logic [31:0] exp_data;
    } vec_t;

    exp_t sb1[$];
    exp_t sb2[$];

    int n_checks = 0, n_fail = 0;
    int wren_cnt = 0, pkt_cnt = 0, err_cnt = 0;
    int wren2_cnt = 0, pkt2_cnt = 0, err2_cnt = 0;
    int cyc = 0, hdr_cyc = 0;
    int w0, p0, e0;

    always #5 clock = ~clock;

    pkt_deframer dut (
        .clock(clock), .aclr(aclr), .sclr(sclr), .ena(ena), .din_valid(din_valid),
        .datain(datain), .wren(wren), .data(data), .waddr(waddr), .o_header(o_header),
        .header_ena(header_ena), .pkt_done(pkt_done), .err_short(err_short)
    );

    pkt_deframer #(.HDR_WORDS(1), .PAYLOAD_BYTES(4), .OUT_BYTES(4), .BIG_ENDIAN(0)) dut2 (
        .clock(clock), .aclr(aclr), .sclr(sclr), .ena(ena2), .din_valid(din_valid2),
        .datain(datain2), .wren(wren2), .data(data2), .waddr(waddr2), .o_header(o_header2),
        .header_ena(header_ena2), .pkt_done(pkt_done2), .err_short(err_short2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every write strobe pops the next expected word.
    task automatic monitor();
        exp_t e;
        if (wren) begin
            wren_cnt++;
            if (sb1.size() == 0) check("wren_unexpected", 64'(wren), 64'(0));
            else begin
                e = sb1.pop_front();
                check("data", 64'(data), 64'(e.data));
                check("waddr", 64'(waddr), 64'(e.waddr));
                check("pkt_done_on_wren", 64'(pkt_done), 64'(e.done));
            end
        end else if (pkt_done) check("pkt_done_without_wren", 64'(pkt_done), 64'(0));
        if (pkt_done) pkt_cnt++;
        if (err_short) err_cnt++;
        if (header_ena && hdr_cyc == 0) hdr_cyc = cyc;

        if (wren2) begin
            wren2_cnt++;
            if (sb2.size() == 0) check("wren2_unexpected", 64'(wren2), 64'(0));
            else begin
                e = sb2.pop_front();
                check("data2", 64'(data2), 64'(e.data));
                check("waddr2", 64'(waddr2), 64'(e.waddr));
                check("pkt_done2_on_wren", 64'(pkt_done2), 64'(e.done));
            end
        end else if (pkt_done2) check("pkt_done2_without_wren", 64'(pkt_done2), 64'(0));
        if (pkt_done2) pkt2_cnt++;
        if (err_short2) err2_cnt++;
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        @(negedge clock);
        monitor();
    endtask

    task automatic idle(input int n);
        ena = 1'b0; din_valid = 1'b0; datain = 8'h00;
        repeat (n) tick();
    endtask

    task automatic send_raw(input logic [7:0] b);
        ena = 1'b1; din_valid = 1'b1; datain = b;
        tick();
    endtask

    // Byte i of a frame is base+i; cycle 1 is the cycle byte 0 is presented.
    task automatic send_frame(input int nbytes, input logic [7:0] base, input bit gaps);
        logic [7:0] b, prev;
        exp_t e;
        prev = 8'h00;
        cyc = 1;
        hdr_cyc = 0;
        for (int i = 0; i < nbytes; i++) begin
            b = base + 8'(i);
            if (i >= HB && ((i - HB) % OB) == OB - 1) begin
                e.data  = {16'h0, prev, b};
                e.waddr = (i - HB) / OB;
                e.done  = ((i - HB) / OB == NW - 1);
                sb1.push_back(e);
            end
            send_raw(b);
            if (gaps && i != nbytes - 1) begin
                din_valid = 1'b0; datain = 8'($urandom);
                tick();
            end
            prev = b;
        end
    endtask

    task automatic check_header(input logic [7:0] base, input string tag);
        logic [31:0] exp_w;
        for (int j = 0; j < HW; j++) begin
            exp_w = {base + 8'(4*j), base + 8'(4*j+1), base + 8'(4*j+2), base + 8'(4*j+3)};
            check(tag, 64'(o_header[32*(HW-j)-1 -: 32]), 64'(exp_w));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wren"}, 64'(wren), 64'(0));
        check({tag, "_data"}, 64'(data), 64'(0));
        check({tag, "_waddr"}, 64'(waddr), 64'(0));
        check({tag, "_o_header"}, 64'(|o_header), 64'(0));
        check({tag, "_header_ena"}, 64'(header_ena), 64'(0));
        check({tag, "_pkt_done"}, 64'(pkt_done), 64'(0));
        check({tag, "_err_short"}, 64'(err_short), 64'(0));
    endtask

    task automatic snap();
        w0 = wren_cnt; p0 = pkt_cnt; e0 = err_cnt;
    endtask

    initial begin
        vec_t vecs[4];
        exp_t e;
        vecs[0] = '{hdr: 32'hA0A1A2A3, pay: 32'h11223344, exp_data: 32'h44332211};
        vecs[1] = '{hdr: 32'h01020304, pay: 32'hDEADBEEF, exp_data: 32'hEFBEADDE};
        vecs[2] = '{hdr: 32'hFFEEDDCC, pay: 32'h00FF00FF, exp_data: 32'hFF00FF00};
        vecs[3] = '{hdr: 32'h5A5A0000, pay: 32'h01020304, exp_data: 32'h04030201};

        aclr = 1'b1; sclr = 1'b0; ena = 1'b0; din_valid = 1'b0; datain = 8'h00;
        ena2 = 1'b0; din_valid2 = 1'b0; datain2 = 8'h00;
        #12;
        check_zero("por");
        aclr = 1'b0;
        @(negedge clock);
        idle(2);

        // Back-to-back default frame, then trailing bytes in DONE.
        snap();
        send_frame(FRAME, 8'h00, 1'b0);
        check("t1_header_ena_cycle", 64'(hdr_cyc), 64'(125));
        check("t1_wren_count", 64'(wren_cnt - w0), 64'(NW));
        check("t1_pkt_done_count", 64'(pkt_cnt - p0), 64'(1));
        check_header(8'h00, "t1_header");
        for (int i = 0; i < 10; i++) send_raw(8'hA0 + 8'(i));
        check("t1_extra_wren", 64'(wren_cnt - w0), 64'(NW));
        check("t1_header_ena_held", 64'(header_ena), 64'(1));
        idle(1);
        check("t1_header_ena_clear", 64'(header_ena), 64'(0));
        check("t1_waddr_clear", 64'(waddr), 64'(0));
        check("t1_err_count", 64'(err_cnt - e0), 64'(0));
        check("t1_header_kept", 64'(o_header[32*HW-1 -: 32]), 64'(32'h00010203));

        // Same frame with din_valid toggling every other cycle.
        snap();
        send_frame(FRAME, 8'h00, 1'b1);
        check("t2_header_ena_cycle", 64'(hdr_cyc), 64'(248));
        check("t2_wren_count", 64'(wren_cnt - w0), 64'(NW));
        check("t2_pkt_done_count", 64'(pkt_cnt - p0), 64'(1));
        check_header(8'h00, "t2_header");
        idle(1);
        check("t2_err_count", 64'(err_cnt - e0), 64'(0));

        // ena dropped after payload byte 3, then a fresh frame.
        snap();
        send_frame(HB + 3, 8'h00, 1'b0);
        idle(1);
        check("t3_err_pulse", 64'(err_short), 64'(1));
        idle(1);
        check("t3_err_single", 64'(err_short), 64'(0));
        check("t3_wren_count", 64'(wren_cnt - w0), 64'(1));
        check("t3_pkt_done_count", 64'(pkt_cnt - p0), 64'(0));
        check("t3_err_count", 64'(err_cnt - e0), 64'(1));
        check("t3_header_ena", 64'(header_ena), 64'(0));
        snap();
        send_frame(FRAME, 8'h40, 1'b0);
        check("t3_next_wren_count", 64'(wren_cnt - w0), 64'(NW));
        check("t3_next_pkt_done", 64'(pkt_cnt - p0), 64'(1));
        check_header(8'h40, "t3_next_header");
        idle(1);

        // ena dropped inside the header.
        snap();
        send_frame(10, 8'h20, 1'b0);
        idle(1);
        check("t4_err_pulse", 64'(err_short), 64'(1));
        check("t4_header_ena", 64'(header_ena), 64'(0));
        idle(1);
        check("t4_wren_count", 64'(wren_cnt - w0), 64'(0));

        // Synchronous clear mid-payload; bytes ignored until ena cycles low.
        snap();
        send_frame(HB + 10, 8'h10, 1'b0);
        sclr = 1'b1; ena = 1'b1; din_valid = 1'b1; datain = 8'h55;
        tick();
        sclr = 1'b0;
        check_zero("t5_sclr");
        for (int i = 0; i < 10; i++) send_raw(8'hC0 + 8'(i));
        check("t5_header_ignored", 64'(|o_header), 64'(0));
        check("t5_header_ena", 64'(header_ena), 64'(0));
        idle(1);
        check("t5_no_err", 64'(err_short), 64'(0));
        check("t5_wren_count", 64'(wren_cnt - w0), 64'(5));
        check("t5_err_count", 64'(err_cnt - e0), 64'(0));

        // Asynchronous clear between edges while a write strobe is high.
        snap();
        send_frame(HB + 20, 8'h30, 1'b0);
        check("t6_wren_before_aclr", 64'(wren), 64'(1));
        #2 aclr = 1'b1;
        #1 check_zero("t6_aclr");
        #1 aclr = 1'b0;
        for (int i = 0; i < 20; i++) send_raw(8'hE0 + 8'(i));
        check("t6_header_ignored", 64'(|o_header), 64'(0));
        check("t6_header_ena", 64'(header_ena), 64'(0));
        idle(1);
        check("t6_no_err", 64'(err_short), 64'(0));
        check("t6_wren_count", 64'(wren_cnt - w0), 64'(10));
        check("t6_err_count", 64'(err_cnt - e0), 64'(0));
        snap();
        send_frame(FRAME, 8'h80, 1'b0);
        check("t6_next_wren_count", 64'(wren_cnt - w0), 64'(NW));
        check("t6_next_pkt_done", 64'(pkt_cnt - p0), 64'(1));
        check_header(8'h80, "t6_next_header");
        idle(1);

        // Little-endian 32-bit instance from the vector table.
        for (int v = 0; v < 4; v++) begin
            ena2 = 1'b0; din_valid2 = 1'b0;
            tick();
            for (int k = 0; k < 4; k++) begin
                ena2 = 1'b1; din_valid2 = 1'b1; datain2 = vecs[v].hdr[31-8*k -: 8];
                tick();
            end
            check("t7_header_ena", 64'(header_ena2), 64'(1));
            for (int k = 0; k < 4; k++) begin
                if (k == 3) begin
                    e.data = vecs[v].exp_data; e.waddr = 0; e.done = 1'b1;
                    sb2.push_back(e);
                end
                datain2 = vecs[v].pay[31-8*k -: 8];
                tick();
            end
            check("t7_o_header", 64'(o_header2), 64'(vecs[v].hdr));
        end
        ena2 = 1'b0; din_valid2 = 1'b0;
        tick();
        check("t7_wren_count", 64'(wren2_cnt), 64'(4));
        check("t7_pkt_done_count", 64'(pkt2_cnt), 64'(4));
        check("t7_err_count", 64'(err2_cnt), 64'(0));

        check("sb1_drain", 64'(sb1.size()), 64'(0));
        check("sb2_drain", 64'(sb2.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
